// File: rtl/accum_core_pkg.sv
// accum_core_pkg: opcodes, FSM states and width helpers for the accumulator core
package accum_core_pkg;
  localparam int OP_W = 4;
  localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_LDI  = 4'h1;
  localparam logic [OP_W-1:0] OP_ADDI = 4'h2;
  localparam logic [OP_W-1:0] OP_SUBI = 4'h3;
  localparam logic [OP_W-1:0] OP_ANDI = 4'h4;
  localparam logic [OP_W-1:0] OP_ORI  = 4'h5;
  localparam logic [OP_W-1:0] OP_XORI = 4'h6;
  localparam logic [OP_W-1:0] OP_SHL  = 4'h7;
  localparam logic [OP_W-1:0] OP_SHR  = 4'h8;
  localparam logic [OP_W-1:0] OP_JMP  = 4'h9;
  localparam logic [OP_W-1:0] OP_BZ   = 4'hA;
  localparam logic [OP_W-1:0] OP_BNZ  = 4'hB;
  localparam logic [OP_W-1:0] OP_MUL  = 4'hC;
  localparam logic [OP_W-1:0] OP_HALT = 4'hD;
  typedef enum logic [1:0] {ST_RUN, ST_MUL, ST_HALT} state_t;
  function automatic int cnt_w(int steps);
    return $clog2(steps + 1);
  endfunction
endpackage

// File: rtl/accum_mul_seq.sv
// accum_mul_seq: shift-add multiplier, one multiplier bit per cycle, done on the last step
module accum_mul_seq
  import accum_core_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMM_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [IMM_W-1:0]  b,
  output logic              done,
  output logic [DATA_W-1:0] product
);
  localparam int CW = cnt_w(IMM_W);
  logic run;
  logic [DATA_W-1:0] mcand, part;
  logic [IMM_W-1:0] mplier;
  logic [CW-1:0] cnt;
  assign product = part + (mplier[0] ? mcand : '0);
  assign done = run && cnt == CW'(IMM_W - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run <= 1'b0;
      mcand <= '0;
      mplier <= '0;
      part <= '0;
      cnt <= '0;
    end else if (start) begin
      run <= 1'b1;
      mcand <= a;
      mplier <= b;
      part <= '0;
      cnt <= '0;
    end else if (run) begin
      part <= product;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + 1'b1;
      run <= !done;
    end
  end
endmodule

// File: rtl/accum_core_param.sv
// accum_core_param: parametrised accumulator core with handshake, flags, sequential multiply and halt
module accum_core_param
  import accum_core_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int IMM_W  = 4
) (
  input  logic              clk,
  input  logic              CLB,
  input  logic [IMM_W+3:0]  input_ins,
  input  logic              ins_valid,
  output logic              ins_ready,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] accum_value,
  output logic              carry,
  output logic              zero,
  output logic              busy,
  output logic              halted,
  output logic              illegal
);
  state_t st, st_n;
  logic [OP_W-1:0] op;
  logic [IMM_W-1:0] imm;
  logic [DATA_W-1:0] immz, acc_n, mprod;
  logic [DATA_W:0] sum, dif;
  logic [PC_W-1:0] pc_n, pc_inc, pc_br;
  logic carry_n, ill_n, accept, mdone;
  assign op = input_ins[IMM_W+3:IMM_W];
  assign imm = input_ins[IMM_W-1:0];
  assign immz = DATA_W'(imm);
  assign sum = {1'b0, accum_value} + {1'b0, immz};
  assign dif = {1'b0, accum_value} - {1'b0, immz};
  assign pc_inc = pc + 1'b1;
  assign pc_br = pc + PC_W'($signed(imm));
  assign accept = ins_valid && st == ST_RUN;
  assign zero = accum_value == '0;
  assign ins_ready = st == ST_RUN;
  assign busy = st == ST_MUL;
  assign halted = st == ST_HALT;
  accum_mul_seq #(.DATA_W(DATA_W), .IMM_W(IMM_W)) u_mul (
    .clk(clk), .rst(CLB), .start(accept && op == OP_MUL), .a(accum_value), .b(imm),
    .done(mdone), .product(mprod)
  );
  always_comb begin
    acc_n = accum_value;
    pc_n = pc;
    carry_n = carry;
    st_n = st;
    ill_n = 1'b0;
    if (st == ST_MUL && mdone) begin
      acc_n = mprod;
      pc_n = pc_inc;
      st_n = ST_RUN;
    end else if (accept) begin
      pc_n = pc_inc;
      case (op)
        OP_NOP:  ;
        OP_LDI:  acc_n = immz;
        OP_ADDI: {carry_n, acc_n} = sum;
        OP_SUBI: {carry_n, acc_n} = dif;
        OP_ANDI: acc_n = accum_value & immz;
        OP_ORI:  acc_n = accum_value | immz;
        OP_XORI: acc_n = accum_value ^ immz;
        OP_SHL:  acc_n = accum_value << imm;
        OP_SHR:  acc_n = accum_value >> imm;
        OP_JMP:  pc_n = pc_br;
        OP_BZ:   pc_n = zero ? pc_br : pc_inc;
        OP_BNZ:  pc_n = zero ? pc_inc : pc_br;
        OP_MUL: begin
          pc_n = pc;
          st_n = ST_MUL;
        end
        OP_HALT: begin
          pc_n = pc;
          st_n = ST_HALT;
        end
        default: ill_n = 1'b1;
      endcase
    end
  end
  always_ff @(posedge clk or posedge CLB) begin
    if (CLB) begin
      st <= ST_RUN;
      pc <= '0;
      accum_value <= '0;
      carry <= 1'b0;
      illegal <= 1'b0;
    end else begin
      st <= st_n;
      pc <= pc_n;
      accum_value <= acc_n;
      carry <= carry_n;
      illegal <= ill_n;
    end
  end
endmodule

// File: tb/tb_accum_core_param.sv
// tb_accum_core_param: randomized and directed checks of accum_core_param against an arithmetic model
module tb_accum_core_param;
  localparam int DW = 8, PW = 8, IW = 4;
  localparam int DM = (1 << DW) - 1, PM = (1 << PW) - 1;
  logic clk = 1'b0, CLB = 1'b1, ins_valid = 1'b0;
  logic [IW+3:0] input_ins = '0;
  logic ins_ready, carry, zero, busy, halted, illegal;
  logic [PW-1:0] pc;
  logic [DW-1:0] accum_value;
  int checks = 0, passes = 0;
  int m_acc, m_pc, m_carry, m_mul, m_prod, m_halt, m_ill;
  bit live = 1'b0;
  always #5 clk = ~clk;
  accum_core_param #(.DATA_W(DW), .PC_W(PW), .IMM_W(IW)) dut (
    .clk(clk), .CLB(CLB), .input_ins(input_ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .pc(pc), .accum_value(accum_value), .carry(carry), .zero(zero), .busy(busy),
    .halted(halted), .illegal(illegal)
  );
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a == e) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", n, a, e);
  endtask
  function automatic int sext(input int i);
    return i >= (1 << (IW - 1)) ? i - (1 << IW) : i;
  endfunction
  task automatic model_reset();
    m_acc = 0; m_pc = 0; m_carry = 0; m_mul = 0; m_prod = 0; m_halt = 0; m_ill = 0;
  endtask
  task automatic model_step();
    int op, imm, nxt;
    m_ill = 0;
    if (m_halt != 0) return;
    if (m_mul > 0) begin
      m_mul--;
      if (m_mul == 0) begin
        m_acc = m_prod;
        m_pc = (m_pc + 1) & PM;
      end
    end else if (ins_valid) begin
      op = int'(input_ins[IW+3:IW]);
      imm = int'(input_ins[IW-1:0]);
      nxt = (m_pc + 1) & PM;
      case (op)
        1: m_acc = imm;
        2: begin m_carry = int'(m_acc + imm > DM); m_acc = (m_acc + imm) & DM; end
        3: begin m_carry = int'(imm > m_acc); m_acc = (m_acc - imm) & DM; end
        4: m_acc = m_acc & imm;
        5: m_acc = m_acc | imm;
        6: m_acc = m_acc ^ imm;
        7: m_acc = imm >= DW ? 0 : (m_acc << imm) & DM;
        8: m_acc = imm >= DW ? 0 : m_acc >> imm;
        9: nxt = (m_pc + sext(imm)) & PM;
        10: if (m_acc == 0) nxt = (m_pc + sext(imm)) & PM;
        11: if (m_acc != 0) nxt = (m_pc + sext(imm)) & PM;
        12: begin m_mul = IW; m_prod = (m_acc * imm) & DM; nxt = m_pc; end
        13: begin m_halt = 1; nxt = m_pc; end
        14, 15: m_ill = 1;
        default: ;
      endcase
      m_pc = nxt;
    end
  endtask
  always @(negedge clk) begin
    if (live && !CLB) begin
      chk("acc", int'(accum_value), m_acc);
      chk("pc", int'(pc), m_pc);
      chk("carry", int'(carry), m_carry);
      chk("zero", int'(zero), int'(m_acc == 0));
      chk("ins_ready", int'(ins_ready), int'(m_halt == 0 && m_mul == 0));
      chk("busy", int'(busy), int'(m_mul > 0));
      chk("halted", int'(halted), m_halt);
      chk("illegal", int'(illegal), m_ill);
    end
  end
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic send(input logic [IW+3:0] ins);
    ins_valid = 1'b1;
    input_ins = ins;
    tick();
    ins_valid = 1'b0;
  endtask
  task automatic do_reset();
    ins_valid = 1'b0;
    #1 CLB = 1'b1;
    model_reset();
    #1;
    chk("rst_acc", int'(accum_value), 0);
    chk("rst_pc", int'(pc), 0);
    chk("rst_carry", int'(carry), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_illegal", int'(illegal), 0);
    @(negedge clk);
    #1 CLB = 1'b0;
    tick();
  endtask
  initial begin
    model_reset();
    #3;
    chk("init_acc", int'(accum_value), 0);
    chk("init_pc", int'(pc), 0);
    @(negedge clk);
    #1 CLB = 1'b0;
    live = 1'b1;
    tick();
    chk("ready_after_reset", int'(ins_ready), 1);
    send(8'h15);
    chk("ldi5", int'({accum_value, pc}), 16'h0501);
    send(8'h23);
    chk("addi3", int'({accum_value, pc}), 16'h0802);
    send(8'h1F); send(8'h74); send(8'h5F);
    chk("acc_ff", int'(accum_value), 8'hFF);
    send(8'h21);
    chk("wrap_acc", int'(accum_value), 0);
    chk("wrap_carry", int'(carry), 1);
    chk("wrap_zero", int'(zero), 1);
    send(8'h31);
    chk("borrow_acc", int'(accum_value), 8'hFF);
    chk("borrow_carry", int'(carry), 1);
    send(8'h89);
    chk("shr_big", int'(accum_value), 0);
    repeat (3) tick();
    chk("idle_pc", int'(pc), 8'h08);
    do_reset();
    send(8'h17);
    send(8'hC6);
    chk("mul_busy0", int'(busy), 1);
    chk("mul_ready0", int'(ins_ready), 0);
    for (int i = 0; i < 4; i++) begin
      ins_valid = 1'b1;
      input_ins = (IW + 4)'($urandom);
      tick();
      if (i < 3) chk("mul_busy", int'(busy), 1);
    end
    ins_valid = 1'b0;
    chk("mul_done", int'(busy), 0);
    chk("mul_acc", int'(accum_value), 8'h2A);
    chk("mul_pc", int'(pc), 2);
    do_reset();
    send(8'h97); send(8'h97); send(8'h92);
    chk("pc_10", int'(pc), 8'h10);
    send(8'hAD);
    chk("bz_back", int'(pc), 8'h0D);
    send(8'hB5);
    chk("bnz_fall", int'(pc), 8'h0E);
    do_reset();
    send(8'h9F);
    chk("jmp_wrap", int'(pc), 8'hFF);
    do_reset();
    send(8'hE0);
    chk("illegal_pulse", int'(illegal), 1);
    chk("illegal_pc", int'(pc), 1);
    tick();
    chk("illegal_clear", int'(illegal), 0);
    send(8'h1A);
    send(8'hD0);
    chk("halt_flag", int'(halted), 1);
    chk("halt_ready", int'(ins_ready), 0);
    for (int i = 0; i < 10; i++) begin
      ins_valid = 1'b1;
      input_ins = (IW + 4)'($urandom);
      tick();
    end
    ins_valid = 1'b0;
    chk("halt_pc", int'(pc), 2);
    chk("halt_acc", int'(accum_value), 8'h0A);
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ((m_halt != 0 && $urandom_range(0, 7) == 0) || (m_mul > 0 && $urandom_range(0, 30) == 0))
        do_reset();
      else begin
        ins_valid = $urandom_range(0, 3) != 0;
        input_ins = (IW + 4)'($urandom);
        tick();
      end
    end
    ins_valid = 1'b0;
    tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
